mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit in the EX stage, directly downstream of the ALU operand mux.
- Consumes the two selected operands for MULT/MULTU/DIV/DIVU/MTHI/MTLO and produces the architectural HI and LO registers.
- Asserts busy so hazard logic stalls MFHI/MFLO and any further mult/div until the result is written.

Parameters:
- WIDTH, `WORD_SIZE (32), operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  3  operation code (see Decomposition)
- src_a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
- src_b  input  WIDTH  rt operand (divisor / multiplier)
- flush  input  1  cancel any in-flight operation (exception/branch flush)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated by mult/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op=MTHI: hi<=src_a at that edge; busy stays 0; done stays 0. MTLO writes lo the same way.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}: latch operands (signed ops latch absolute values plus result signs), count<=0, go to RUN. busy=1 from the next cycle.
- RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle. After WIDTH steps (count==WIDTH-1), go to FIX.
- FIX: apply sign correction and write hi/lo; go to IDLE; done=1 for exactly that one following cycle; busy=0 in the same cycle.
- Latency: start edge E0 -> hi/lo valid and done=1 after edge E0+WIDTH+1, i.e. 33 edges at WIDTH=32. busy is high for WIDTH+1 cycles.
- Multiply: {hi,lo} = full 2*WIDTH product. MULT is signed, MULTU is unsigned.
- Divide: lo=quotient, hi=remainder. Signed ops truncate toward zero; the remainder takes the sign of the dividend.
- Divide by zero (any signedness): lo=all ones, hi=src_a. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored; the in-flight operation is unaffected.
- Reserved op with start=1: no-op; stays IDLE.
- flush=1 in RUN or FIX: return to IDLE next edge. hi/lo are unchanged, done=0, busy=0 next cycle.
- flush=1 in IDLE together with start: flush wins; no write, no launch.
- Reset asserted mid-operation: immediate return to reset values. A partial result is never written.
- hi/lo change only in FIX, on MTHI/MTLO, or on reset.

Decomposition:
- definitions.vh holds the op codes: MD_MULT=3'b000, MD_MULTU=3'b001, MD_DIV=3'b010, MD_DIVU=3'b011, MD_MTHI=3'b100, MD_MTLO=3'b101; 110 and 111 are reserved.
- The state encoding also lives in definitions.vh: IDLE=2'b00, RUN=2'b01, FIX=2'b10.
- One sub-module, md_sign_fix: combinational absolute-value of inputs and final negation of quotient/remainder/product per op. It is shared by the entry and FIX logic.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy high for 33 cycles.
- MULT -3 x 7 (0xFFFFFFFD, 0x7) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in back-to-back cycles -> hi/lo updated on each edge, busy never asserts.
- MULT launched, second start at cycle 10 with different operands, flush at cycle 20 of a third op -> second start ignored, first result correct, flushed op leaves hi/lo equal to the first result with no done pulse.
- rst pulsed asynchronously mid-RUN (between clock edges) -> busy/done/hi/lo go to 0 immediately; next start runs normally.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, FSM states and word size for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

    localparam int unsigned WORD_SIZE = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e f_op);
        return (f_op == MD_MULT) || (f_op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Magnitude extraction of operands at launch and sign restoration of the
// unsigned iterative result at writeback.
module md_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_abs_a,
    output logic [WIDTH-1:0] o_abs_b,
    output logic             o_neg_a,
    output logic             o_neg_b,
    input  logic             i_is_mul,
    input  logic             i_neg_hi,
    input  logic             i_neg_lo,
    input  logic [WIDTH-1:0] i_raw_hi,
    input  logic [WIDTH-1:0] i_raw_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    always_comb begin
        o_neg_a = i_signed & i_a[WIDTH-1];
        o_neg_b = i_signed & i_b[WIDTH-1];
        o_abs_a = o_neg_a ? ('0 - i_a) : i_a;
        o_abs_b = o_neg_b ? ('0 - i_b) : i_b;

        w_prod     = {i_raw_hi, i_raw_lo};
        w_prod_neg = '0 - w_prod;

        // Product negates as one 2*WIDTH value; quotient and remainder independently.
        if (i_is_mul) begin
            o_hi = i_neg_lo ? w_prod_neg[2*WIDTH-1:WIDTH] : i_raw_hi;
            o_lo = i_neg_lo ? w_prod_neg[WIDTH-1:0]       : i_raw_lo;
        end else begin
            o_hi = i_neg_hi ? ('0 - i_raw_hi) : i_raw_hi;
            o_lo = i_neg_lo ? ('0 - i_raw_lo) : i_raw_lo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// subtract-shift step per cycle, sign handled outside the iteration.
import mult_div_unit_pkg::*;

module mult_div_unit #(
    parameter int unsigned WIDTH = WORD_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_e        r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_is_mul;
    logic             r_neg_hi;
    logic             r_neg_lo;

    md_op_e           w_op;
    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_next_acc;
    logic [WIDTH-1:0] w_next_q;

    assign w_op     = md_op_e'(op);
    assign w_signed = md_is_signed(w_op);

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_signed (w_signed),
        .i_a      (src_a),
        .i_b      (src_b),
        .o_abs_a  (w_abs_a),
        .o_abs_b  (w_abs_b),
        .o_neg_a  (w_neg_a),
        .o_neg_b  (w_neg_b),
        .i_is_mul (r_is_mul),
        .i_neg_hi (r_neg_hi),
        .i_neg_lo (r_neg_lo),
        .i_raw_hi (r_acc),
        .i_raw_lo (r_q),
        .o_hi     (w_fix_hi),
        .o_lo     (w_fix_lo)
    );

    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
        w_shift = {r_acc, r_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_m};
        if (r_is_mul) begin
            w_next_acc = w_sum[WIDTH:1];
            w_next_q   = {w_sum[0], r_q[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            w_next_acc = w_diff[WIDTH-1:0];
            w_next_q   = {r_q[WIDTH-2:0], 1'b1};
        end else begin
            w_next_acc = w_shift[WIDTH-1:0];
            w_next_q   = {r_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_is_mul <= 1'b0;
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !flush) begin
                        case (w_op)
                            MD_MTHI: hi <= src_a;
                            MD_MTLO: lo <= src_a;
                            MD_MULT, MD_MULTU: begin
                                r_acc    <= '0;
                                r_m      <= w_abs_a;
                                r_q      <= w_abs_b;
                                r_is_mul <= 1'b1;
                                r_neg_hi <= 1'b0;
                                r_neg_lo <= w_neg_a ^ w_neg_b;
                                r_count  <= '0;
                                busy     <= 1'b1;
                                r_state  <= RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_acc    <= '0;
                                r_m      <= w_abs_b;
                                r_q      <= w_abs_a;
                                r_is_mul <= 1'b0;
                                r_neg_hi <= w_neg_a;
                                // A zero divisor leaves an all-ones quotient that must not be negated.
                                r_neg_lo <= (w_neg_a ^ w_neg_b) && (src_b != '0);
                                r_count  <= '0;
                                busy     <= 1'b1;
                                r_state  <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_acc   <= w_next_acc;
                        r_q     <= w_next_q;
                        r_count <= r_count + CW'(1);
                        if (r_count == CW'(WIDTH - 1)) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                    if (!flush) begin
                        hi   <= w_fix_hi;
                        lo   <= w_fix_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
